vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_pkg.sv | 17 +
 rtl/fb_addr_gen.sv | 40 ++++
 rtl/vga_fb_arbiter.sv | 159 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and frame-buffer arbiter types, also used by the
// h/v counter blocks.
package vga_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_FB_W      = 160;
    localparam int VGA_FB_H      = 120;
    localparam int VGA_DATA_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DISP_RD = 2'd1,
        ST_WR      = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Combinational screen-to-buffer address mapping: downscaled row*FB_W + column,
// built from constant shifts and adds, plus the active-video flag.
module fb_addr_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE   = VGA_H_VISIBLE,
    parameter int V_VISIBLE   = VGA_V_VISIBLE,
    parameter int SCALE_SHIFT = 2,
    parameter int FB_W        = VGA_FB_W,
    parameter int ADDR_W      = 15
) (
    input  logic [10:0]       h_count,
    input  logic [10:0]       v_count,
    output logic [ADDR_W-1:0] addr,
    output logic              active
);

    localparam logic [31:0] FB_W_BITS = FB_W;

    logic [10:0]       w_col;
    logic [10:0]       w_row;
    logic [ADDR_W-1:0] w_row_base;

    assign w_col = h_count >> SCALE_SHIFT;
    assign w_row = v_count >> SCALE_SHIFT;

    // Row times the constant FB_W: one shifted copy of the row per set bit.
    always_comb begin
        w_row_base = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (FB_W_BITS[i]) begin
                w_row_base = w_row_base + (ADDR_W'(w_row) << i);
            end
        end
    end

    assign addr   = w_row_base + ADDR_W'(w_col);
    assign active = (h_count < 11'(H_VISIBLE)) && (v_count < 11'(V_VISIBLE));

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: the display read owns every active pixel
// tick, matrix-result writes take the remaining cycles.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int H_VISIBLE   = VGA_H_VISIBLE,
    parameter int V_VISIBLE   = VGA_V_VISIBLE,
    parameter int SCALE_SHIFT = 2,
    parameter int FB_W        = VGA_FB_W,
    parameter int FB_H        = VGA_FB_H,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = VGA_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic [10:0]       h_count,
    input  logic [10:0]       v_count,
    input  logic              frame_start,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic [15:0]       wr_count,
    output arb_state_t        o_dbg_state
);

    localparam logic [ADDR_W:0] FB_WORDS = (ADDR_W + 1)'(FB_W * FB_H);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [ADDR_W-1:0] w_disp_addr;
    logic              w_active;
    logic [ADDR_W-1:0] r_disp_addr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_wr_ok;
    logic              r_rd_ret;
    logic [DATA_W-1:0] r_pix;
    logic [15:0]       r_wr_count;
    logic              w_wr_inc;

    fb_addr_gen #(
        .H_VISIBLE  (H_VISIBLE),
        .V_VISIBLE  (V_VISIBLE),
        .SCALE_SHIFT(SCALE_SHIFT),
        .FB_W       (FB_W),
        .ADDR_W     (ADDR_W)
    ) u_addr_gen (
        .h_count(h_count),
        .v_count(v_count),
        .addr   (w_disp_addr),
        .active (w_active)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Write handshake: the writer holds wr_req/wr_addr/wr_data until the
    // one-cycle wr_ack; wr_req seen during that ack cycle is the same
    // transaction and is never granted a second time.
    always_comb begin
        w_next_state = ST_IDLE;
        if (clk_en && w_active) begin
            w_next_state = ST_DISP_RD;
        end else if (wr_req && (r_state != ST_WR)) begin
            w_next_state = ST_WR;
        end
    end

    // The counters move on the same edge, so the granted transaction is
    // captured at the decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp_addr <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_ok     <= 1'b0;
        end else begin
            if (w_next_state == ST_DISP_RD) begin
                r_disp_addr <= w_disp_addr;
            end
            if (w_next_state == ST_WR) begin
                r_wr_addr <= wr_addr;
                r_wr_data <= wr_data;
                r_wr_ok   <= ({1'b0, wr_addr} < FB_WORDS);
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_ack    = 1'b0;
        wr_err    = 1'b0;
        case (r_state)
            ST_DISP_RD: begin
                mem_en   = 1'b1;
                mem_addr = r_disp_addr;
            end
            ST_WR: begin
                wr_ack = 1'b1;
                wr_err = !r_wr_ok;
                if (r_wr_ok) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = r_wr_addr;
                    mem_wdata = r_wr_data;
                end
            end
            default: begin
            end
        endcase
    end

    assign w_wr_inc = (r_state == ST_WR) && r_wr_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ret   <= 1'b0;
            r_pix      <= '0;
            r_wr_count <= '0;
        end else begin
            r_rd_ret <= (r_state == ST_DISP_RD);
            if (clk_en && !w_active) begin
                r_pix <= '0;
            end else if (r_rd_ret) begin
                r_pix <= mem_rdata;
            end
            if (frame_start) begin
                r_wr_count <= {15'd0, w_wr_inc};
            end else if (w_wr_inc && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    // Read data shows on the pixel output in its return cycle, then holds.
    assign pix_data    = r_rd_ret ? mem_rdata : r_pix;
    assign pix_valid   = r_rd_ret;
    assign wr_count    = r_wr_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios with literal expectations and a
// cycle-level behavioural model compared against the outputs every cycle.
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 8;
  localparam int FB_WORDS = 19200;

  logic              clk;
  logic              reset;
  logic              clk_en;
  logic [10:0]       h_count;
  logic [10:0]       v_count;
  logic              frame_start;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              wr_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic [15:0]       wr_count;
  arb_state_t        dbg_state;

  int checks = 0;
  int errors = 0;

  vga_fb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .h_count    (h_count),
    .v_count    (v_count),
    .frame_start(frame_start),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .wr_count   (wr_count),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endfunction

  // buffer memory seen by the DUT: one-cycle read latency
  logic [7:0] sim_mem [0:FB_WORDS-1];
  logic [7:0] exp_mem [0:FB_WORDS-1];

  always @(posedge clk) begin
    if (mem_en && mem_we) sim_mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= sim_mem[mem_addr];
  end

  // behavioural model: m_* are the outputs required in the current cycle
  bit m_rd, m_wr, m_err, m_ret;
  int m_addr, m_wdata, m_ret_val, m_hold, m_count;
  bit mdl_act, mdl_rd, mdl_wr;

  always @(posedge clk) begin
    if (reset) begin
      m_rd = 0; m_wr = 0; m_err = 0; m_ret = 0;
      m_addr = 0; m_wdata = 0; m_ret_val = 0; m_hold = 0; m_count = 0;
    end else begin
      mdl_act = (h_count < 640) && (v_count < 480);
      mdl_rd  = clk_en && mdl_act;
      mdl_wr  = !mdl_rd && wr_req && !m_wr;
      if (m_wr && !m_err) exp_mem[m_addr] = 8'(m_wdata);
      if (clk_en && !mdl_act) m_hold = 0;
      else if (m_ret) m_hold = m_ret_val;
      if (frame_start) m_count = (m_wr && !m_err) ? 1 : 0;
      else if (m_wr && !m_err && m_count < 65535) m_count++;
      m_ret = m_rd;
      if (m_rd) m_ret_val = int'(exp_mem[m_addr]);
      m_rd  = mdl_rd;
      m_wr  = mdl_wr;
      m_err = mdl_wr && (int'(wr_addr) >= FB_WORDS);
      if (mdl_rd) m_addr = (int'(v_count) / 4) * 160 + int'(h_count) / 4;
      else if (mdl_wr && !m_err) m_addr = int'(wr_addr);
      else m_addr = 0;
      m_wdata = (mdl_wr && !m_err) ? int'(wr_data) : 0;
    end
  end

  // scoreboard of accepted in-range writes, in request order
  logic [22:0] exp_q[$];
  logic [22:0] exp_w;

  always @(negedge clk) begin
    check("mem_en", int'(mem_en), int'(m_rd || (m_wr && !m_err)));
    check("mem_we", int'(mem_we), int'(m_wr && !m_err));
    check("mem_addr", int'(mem_addr), m_addr);
    check("mem_wdata", int'(mem_wdata), m_wdata);
    check("wr_ack", int'(wr_ack), int'(m_wr));
    check("wr_err", int'(wr_err), int'(m_err));
    check("pix_valid", int'(pix_valid), int'(m_ret));
    check("pix_data", int'(pix_data), m_ret ? m_ret_val : m_hold);
    check("wr_count", int'(wr_count), m_count);
    if (mem_en && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0d with no write pending", mem_addr, mem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        check("wr_seq_addr", int'(mem_addr), int'(exp_w[22:8]));
        check("wr_seq_data", int'(mem_wdata), int'(exp_w[7:0]));
      end
    end
  end

  // driver: writer holds a request until it sees wr_ack, then takes the next
  logic [ADDR_W-1:0] wq_addr[$];
  logic [DATA_W-1:0] wq_data[$];
  bit ack_seen = 0;

  task automatic push_wr(input int a, input int d, input bit track);
    wq_addr.push_back(ADDR_W'(a));
    wq_data.push_back(DATA_W'(d));
    if (track && a < FB_WORDS) exp_q.push_back({ADDR_W'(a), DATA_W'(d)});
  endtask

  task automatic cyc(input bit rst, input bit ce, input int h, input int v, input bit fs);
    @(posedge clk);
    #1;
    if (wr_req && ack_seen) wr_req = 1'b0;
    if (!wr_req && wq_addr.size() > 0) begin
      wr_addr = wq_addr.pop_front();
      wr_data = wq_data.pop_front();
      wr_req  = 1'b1;
    end
    reset       = rst;
    clk_en      = ce;
    h_count     = 11'(h);
    v_count     = 11'(v);
    frame_start = fs;
    @(negedge clk);
    ack_seen = wr_ack;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (wq_addr.size() == 0 && !wr_req) break;
      cyc(0, 0, 0, 490, 0);
    end
    check(name, wq_addr.size() + int'(wr_req), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_state"}, int'(dbg_state), int'(ST_IDLE));
    check({name, "_ack"}, int'(wr_ack), 0);
    check({name, "_err"}, int'(wr_err), 0);
    check({name, "_mem_en"}, int'(mem_en), 0);
    check({name, "_mem_addr"}, int'(mem_addr), 0);
    check({name, "_pix"}, int'(pix_data), 0);
    check({name, "_pix_valid"}, int'(pix_valid), 0);
    check({name, "_count"}, int'(wr_count), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  int early_acks, late_acks;
  bit oob_seen;

  initial begin
    reset = 1'b1; clk_en = 1'b0; h_count = '0; v_count = '0; frame_start = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; mem_rdata = '0;
    for (int i = 0; i < FB_WORDS; i++) begin
      sim_mem[i] = 8'((i * 7) ^ 8'h3C);
      exp_mem[i] = 8'((i * 7) ^ 8'h3C);
    end
    sim_mem[162] = 8'h5A;
    exp_mem[162] = 8'h5A;

    // power-up reset, three clocks
    for (int i = 0; i < 3; i++) cyc(1, 1, 100, 50, 0);
    check_reset_outputs("por");
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // pixel tick 1-in-4 at h=8, v=4: address 162, data two clocks later
    cyc(0, 1, 8, 4, 0);
    cyc(0, 0, 9, 4, 0);
    check("rd_mem_en", int'(mem_en), 1);
    check("rd_mem_we", int'(mem_we), 0);
    check("rd_addr", int'(mem_addr), 162);
    cyc(0, 0, 9, 4, 0);
    check("rd_pix_valid", int'(pix_valid), 1);
    check("rd_pix_data", int'(pix_data), 8'h5A);
    cyc(0, 0, 9, 4, 0);

    // write request coinciding with a display slot waits one cycle
    push_wr(100, 8'h33, 1);
    cyc(0, 1, 12, 4, 0);
    cyc(0, 0, 13, 4, 0);
    check("coll_read_first", int'(mem_en && !mem_we), 1);
    check("coll_no_ack_yet", int'(wr_ack), 0);
    cyc(0, 0, 13, 4, 0);
    check("coll_we", int'(mem_we), 1);
    check("coll_addr", int'(mem_addr), 100);
    check("coll_wdata", int'(mem_wdata), 8'h33);
    check("coll_ack", int'(wr_ack), 1);
    cyc(0, 0, 13, 4, 0);
    cyc(0, 0, 13, 4, 0);

    // read back word 100 from screen position h=400, v=0
    cyc(0, 1, 400, 0, 0);
    cyc(0, 0, 401, 0, 0);
    cyc(0, 0, 401, 0, 0);
    check("readback_pix", int'(pix_data), 8'h33);
    cyc(0, 0, 401, 0, 0);

    // clk_en tied high through one line with a continuous writer
    for (int i = 0; i < 90; i++) push_wr(1000 + i, i + 1, 1);
    early_acks = 0;
    late_acks  = 0;
    for (int h = 600; h < 800; h++) begin
      cyc(0, 1, h, 10, 0);
      if (wr_ack) begin
        if (h <= 640) early_acks++;
        else late_acks++;
      end
    end
    check("line_acks_active", early_acks, 0);
    check("line_acks_blank", late_acks, 80);
    drain("line_drain");
    check("count_after_line", int'(wr_count), 91);

    // out-of-range write: acked with error, no memory cycle, count held
    push_wr(FB_WORDS, 8'h77, 1);
    oob_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 490, 0);
      if (wr_ack) begin
        oob_seen = 1;
        check("oob_err", int'(wr_err), 1);
        check("oob_mem_en", int'(mem_en), 0);
        break;
      end
    end
    check("oob_ack_seen", int'(oob_seen), 1);
    drain("oob_drain");
    cyc(0, 0, 0, 490, 0);
    check("oob_count", int'(wr_count), 91);

    // frame_start clears; 5 writes, then a 6th ack on frame_start
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    check("fs_clear", int'(wr_count), 0);
    for (int i = 0; i < 5; i++) push_wr(2000 + i, 8'hC0 + i, 1);
    drain("five_drain");
    check("five_count", int'(wr_count), 5);
    push_wr(2100, 8'hEE, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("fs_ack", int'(wr_ack), 1);
    check("fs_count_before", int'(wr_count), 5);
    cyc(0, 0, 0, 0, 0);
    check("fs_count_after", int'(wr_count), 1);
    drain("fs_drain");

    // reset held three clocks mid-frame, read in flight, write pending
    push_wr(200, 8'h11, 0);
    cyc(0, 1, 40, 20, 0);
    cyc(1, 0, 41, 20, 0);
    check("pre_rst_read", int'(mem_en), 1);
    cyc(1, 0, 41, 20, 0);
    check_reset_outputs("rst1");
    cyc(1, 0, 41, 20, 0);
    check_reset_outputs("rst2");
    wr_req = 1'b0;
    cyc(0, 0, 41, 20, 0);
    check_reset_outputs("rst3");
    cyc(0, 0, 41, 20, 0);
    check("post_rst_no_ack", int'(wr_ack), 0);
    cyc(0, 0, 41, 20, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
